// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : control_sequencer
// Description : Hardwired step-counter control unit for the single-bus
//               datapath; decodes IR[31:27] into per-step control strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module control_sequencer (
    input  logic        clock,
    input  logic        reset,
    input  logic        stop,
    input  logic [31:0] IR,
    input  logic        CON_FF,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        PCout,
    output logic        PCin,
    output logic        IncPC,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        Zlowout,
    output logic        Cout,
    output logic        CONin,
    output logic        Read,
    output logic        Write,
    output logic [3:0]  alu_op,
    output logic        Run
);

    typedef enum logic [3:0] {
        S_RESET = 4'd0,
        S_T0    = 4'd1,
        S_T1    = 4'd2,
        S_T2    = 4'd3,
        S_T3    = 4'd4,
        S_T4    = 4'd5,
        S_T5    = 4'd6,
        S_T6    = 4'd7,
        S_T7    = 4'd8,
        S_HALT  = 4'd9
    } state_t;

    localparam logic [4:0] C_OP_LD   = 5'b00000;
    localparam logic [4:0] C_OP_LDI  = 5'b00001;
    localparam logic [4:0] C_OP_ST   = 5'b00010;
    localparam logic [4:0] C_OP_ADD  = 5'b00011;
    localparam logic [4:0] C_OP_SUB  = 5'b00100;
    localparam logic [4:0] C_OP_AND  = 5'b00101;
    localparam logic [4:0] C_OP_OR   = 5'b00110;
    localparam logic [4:0] C_OP_ADDI = 5'b01100;
    localparam logic [4:0] C_OP_BR   = 5'b10010;
    localparam logic [4:0] C_OP_HALT = 5'b11011;

    state_t     r_state;
    logic [4:0] w_opcode;
    logic       w_is_alu;
    logic       w_is_addi;
    logic       w_is_ldi;
    logic       w_is_ld;
    logic       w_is_st;
    logic       w_is_br;
    logic       w_is_halt;
    logic       w_is_nop;
    logic       w_last;
    logic [3:0] w_alu_code;
    logic       w_unused;

    assign w_opcode  = IR[31:27];
    assign w_unused  = ^IR[26:0];

    assign w_is_alu  = (w_opcode == C_OP_ADD) || (w_opcode == C_OP_SUB) ||
                       (w_opcode == C_OP_AND) || (w_opcode == C_OP_OR);
    assign w_is_addi = (w_opcode == C_OP_ADDI);
    assign w_is_ldi  = (w_opcode == C_OP_LDI);
    assign w_is_ld   = (w_opcode == C_OP_LD);
    assign w_is_st   = (w_opcode == C_OP_ST);
    assign w_is_br   = (w_opcode == C_OP_BR);
    assign w_is_halt = (w_opcode == C_OP_HALT);
    // Unrecognised opcodes fall through to nop behaviour.
    assign w_is_nop  = !(w_is_alu || w_is_addi || w_is_ldi || w_is_ld ||
                         w_is_st || w_is_br || w_is_halt);

    assign w_last = ((r_state == S_T3) && w_is_nop) ||
                    ((r_state == S_T5) && (w_is_alu || w_is_addi || w_is_ldi)) ||
                    ((r_state == S_T6) && w_is_br) ||
                    ((r_state == S_T7) && (w_is_ld || w_is_st));

    always_comb begin
        case (w_opcode)
            C_OP_SUB: w_alu_code = 4'd1;
            C_OP_AND: w_alu_code = 4'd2;
            C_OP_OR:  w_alu_code = 4'd3;
            default:  w_alu_code = 4'd0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_RESET;
        end else begin
            case (r_state)
                S_RESET: r_state <= S_T0;
                S_HALT:  r_state <= S_HALT;
                default: begin
                    if ((r_state == S_T3) && w_is_halt) begin
                        r_state <= S_HALT;
                    end else if (w_last) begin
                        r_state <= stop ? S_HALT : S_T0;
                    end else begin
                        r_state <= state_t'(r_state + 4'd1);
                    end
                end
            endcase
        end
    end

    always_comb begin
        Gra     = 1'b0;
        Grb     = 1'b0;
        Grc     = 1'b0;
        Rin     = 1'b0;
        Rout    = 1'b0;
        BAout   = 1'b0;
        PCout   = 1'b0;
        PCin    = 1'b0;
        IncPC   = 1'b0;
        MARin   = 1'b0;
        MDRin   = 1'b0;
        MDRout  = 1'b0;
        IRin    = 1'b0;
        Yin     = 1'b0;
        Zin     = 1'b0;
        Zlowout = 1'b0;
        Cout    = 1'b0;
        CONin   = 1'b0;
        Read    = 1'b0;
        Write   = 1'b0;
        alu_op  = 4'd0;
        Run     = (r_state != S_RESET) && (r_state != S_HALT);
        case (r_state)
            S_T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
            end
            S_T1: begin
                Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1; IRin = 1'b1;
            end
            S_T3: begin
                if (w_is_alu || w_is_addi) begin
                    Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                end else if (w_is_ldi || w_is_ld || w_is_st) begin
                    Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
                end else if (w_is_br) begin
                    Gra = 1'b1; Rout = 1'b1; CONin = 1'b1;
                end
            end
            S_T4: begin
                if (w_is_alu) begin
                    Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = w_alu_code;
                end else if (w_is_addi || w_is_ldi || w_is_ld || w_is_st) begin
                    Cout = 1'b1; Zin = 1'b1;
                end else if (w_is_br) begin
                    PCout = 1'b1; Yin = 1'b1;
                end
            end
            S_T5: begin
                if (w_is_alu || w_is_addi || w_is_ldi) begin
                    Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (w_is_ld || w_is_st) begin
                    Zlowout = 1'b1; MARin = 1'b1;
                end else if (w_is_br) begin
                    Cout = 1'b1; Zin = 1'b1;
                end
            end
            S_T6: begin
                if (w_is_ld) begin
                    Read = 1'b1; MDRin = 1'b1;
                end else if (w_is_st) begin
                    // Store data comes off the bus, so the MDR mux must not select memory.
                    Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
                end else if (w_is_br) begin
                    Zlowout = 1'b1; PCin = CON_FF;
                end
            end
            S_T7: begin
                if (w_is_ld) begin
                    MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (w_is_st) begin
                    Write = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire
